apb_arbiter: RTL and testbench

- Two-master, one-slave APB arbiter that shares the system bus.
- Master 0 is the CPU core's fetch/load/store/sys-load port. Master 1 is the debug/DMA port.
- Each accepted transfer is captured into internal registers and replayed on the slave side as a clean SETUP/ACCESS sequence. The response is returned to the owning master as a registered one-cycle pready pulse.
- Also provides round-robin fairness and a slave timeout that turns a hung slave into an error response.

---
 rtl/apb_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_apb_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_arbiter.sv
// ============================================================================
//  Module      : apb_arbiter
//  Description : Two-master / one-slave APB arbiter. A request that wins
//                arbitration is captured and replayed to the slave as a
//                SETUP/ACCESS pair. The response goes back to the owning master
//                as a one-cycle registered pready pulse. When both masters
//                request, round-robin decides. A hung slave is turned into an
//                error response by the ACCESS timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255,
    parameter int TO_WIDTH   = 8
) (
    input  logic                    clk,
    input  logic                    rts_n,
    // master 0 (CPU core)
    input  logic [ADDR_WIDTH-1:0]   m0_paddr,
    input  logic [DATA_WIDTH-1:0]   m0_pdata,
    input  logic [DATA_WIDTH/8-1:0] m0_pstb,
    input  logic                    m0_psel,
    input  logic                    m0_penable,
    input  logic                    m0_pwrite,
    output logic [DATA_WIDTH-1:0]   m0_prdata,
    output logic                    m0_pready,
    output logic                    m0_perr,
    // master 1 (debug / DMA)
    input  logic [ADDR_WIDTH-1:0]   m1_paddr,
    input  logic [DATA_WIDTH-1:0]   m1_pdata,
    input  logic [DATA_WIDTH/8-1:0] m1_pstb,
    input  logic                    m1_psel,
    input  logic                    m1_penable,
    input  logic                    m1_pwrite,
    output logic [DATA_WIDTH-1:0]   m1_prdata,
    output logic                    m1_pready,
    output logic                    m1_perr,
    // shared slave
    output logic [ADDR_WIDTH-1:0]   s_paddr,
    output logic [DATA_WIDTH-1:0]   s_pdata,
    output logic [DATA_WIDTH/8-1:0] s_pstb,
    output logic                    s_psel,
    output logic                    s_penable,
    output logic                    s_pwrite,
    input  logic [DATA_WIDTH-1:0]   s_prdata,
    input  logic                    s_pready,
    input  logic                    s_perr,
    // status
    output logic [1:0]              grant,
    output logic                    busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Value of the counter during the last ACCESS cycle allowed before the
    // response is forced. The counter is zero in the first ACCESS cycle.
    localparam logic [TO_WIDTH-1:0] TO_LAST =
        TO_WIDTH'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic TO_EN = (TIMEOUT != 0);

    state_t                    state_q;
    logic [1:0]                grant_q;
    logic                      last_q;      // index of the master granted last
    logic [TO_WIDTH-1:0]       cnt_q;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [DATA_WIDTH/8-1:0]   stb_q;
    logic                      write_q;
    logic                      psel_q;
    logic                      penable_q;
    logic                      m0_pready_q;
    logic                      m0_perr_q;
    logic [DATA_WIDTH-1:0]     m0_prdata_q;
    logic                      m1_pready_q;
    logic                      m1_perr_q;
    logic [DATA_WIDTH-1:0]     m1_prdata_q;

    logic                      win1_d;      // master 1 wins this evaluation
    logic                      to_hit_d;
    logic                      done_d;
    logic                      rsp_err_d;
    logic [DATA_WIDTH-1:0]     rsp_data_d;

    // penable from the masters plays no part in arbitration or capture
    logic                      w_unused_penable;
    assign w_unused_penable = m0_penable ^ m1_penable;

    // Arbitration and response selection. Master 1 wins when it is the only
    // requester, or when both request and master 0 was the last owner.
    always_comb begin
        win1_d     = m1_psel & (~m0_psel | ~last_q);
        to_hit_d   = TO_EN & (cnt_q == TO_LAST);
        done_d     = s_pready | to_hit_d;
        // a timeout reports an error with zero data; writes never return data
        rsp_err_d  = s_pready ? s_perr : 1'b1;
        rsp_data_d = (s_pready && !write_q) ? s_prdata : '0;
    end

    // Transfer FSM with all bus-facing outputs registered
    always_ff @(posedge clk or negedge rts_n) begin
        if (!rts_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= 2'b00;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            stb_q       <= '0;
            write_q     <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            m0_pready_q <= 1'b0;
            m0_perr_q   <= 1'b0;
            m0_prdata_q <= '0;
            m1_pready_q <= 1'b0;
            m1_perr_q   <= 1'b0;
            m1_prdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (m0_psel || m1_psel) begin
                        addr_q    <= win1_d ? m1_paddr  : m0_paddr;
                        wdata_q   <= win1_d ? m1_pdata  : m0_pdata;
                        stb_q     <= win1_d ? m1_pstb   : m0_pstb;
                        write_q   <= win1_d ? m1_pwrite : m0_pwrite;
                        grant_q   <= win1_d ? 2'b10 : 2'b01;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        state_q   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (done_d) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        state_q   <= ST_RESP;
                        if (grant_q[1]) begin
                            m1_pready_q <= 1'b1;
                            m1_perr_q   <= rsp_err_d;
                            m1_prdata_q <= rsp_data_d;
                        end else begin
                            m0_pready_q <= 1'b1;
                            m0_perr_q   <= rsp_err_d;
                            m0_prdata_q <= rsp_data_d;
                        end
                    end else begin
                        cnt_q <= cnt_q + TO_WIDTH'(1);
                    end
                end
                ST_RESP: begin
                    m0_pready_q <= 1'b0;
                    m0_perr_q   <= 1'b0;
                    m0_prdata_q <= '0;
                    m1_pready_q <= 1'b0;
                    m1_perr_q   <= 1'b0;
                    m1_prdata_q <= '0;
                    last_q      <= grant_q[1];
                    grant_q     <= 2'b00;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign s_paddr   = addr_q;
    assign s_pdata   = wdata_q;
    assign s_pstb    = stb_q;
    assign s_pwrite  = write_q;
    assign s_psel    = psel_q;
    assign s_penable = penable_q;
    assign m0_pready = m0_pready_q;
    assign m0_perr   = m0_perr_q;
    assign m0_prdata = m0_prdata_q;
    assign m1_pready = m1_pready_q;
    assign m1_perr   = m1_perr_q;
    assign m1_prdata = m1_prdata_q;
    assign grant     = grant_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_apb_arbiter.sv
// ============================================================================
//  Module      : tb_apb_arbiter
//  Description : Self-checking bench for apb_arbiter (TIMEOUT = 8). Directed
//                scenarios followed by randomized transfers checked against a
//                transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rts_n;
    logic [31:0] m0_paddr, m0_pdata, m1_paddr, m1_pdata;
    logic [3:0]  m0_pstb, m1_pstb;
    logic        m0_psel, m0_penable, m0_pwrite;
    logic        m1_psel, m1_penable, m1_pwrite;
    logic [31:0] m0_prdata, m1_prdata;
    logic        m0_pready, m0_perr, m1_pready, m1_perr;
    logic [31:0] s_paddr, s_pdata, s_prdata;
    logic [3:0]  s_pstb;
    logic        s_psel, s_penable, s_pwrite, s_pready, s_perr;
    logic [1:0]  grant;
    logic        busy;

    apb_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .TIMEOUT    (TO),
        .TO_WIDTH   (8)
    ) dut (
        .clk        (clk),
        .rts_n      (rts_n),
        .m0_paddr   (m0_paddr),
        .m0_pdata   (m0_pdata),
        .m0_pstb    (m0_pstb),
        .m0_psel    (m0_psel),
        .m0_penable (m0_penable),
        .m0_pwrite  (m0_pwrite),
        .m0_prdata  (m0_prdata),
        .m0_pready  (m0_pready),
        .m0_perr    (m0_perr),
        .m1_paddr   (m1_paddr),
        .m1_pdata   (m1_pdata),
        .m1_pstb    (m1_pstb),
        .m1_psel    (m1_psel),
        .m1_penable (m1_penable),
        .m1_pwrite  (m1_pwrite),
        .m1_prdata  (m1_prdata),
        .m1_pready  (m1_pready),
        .m1_perr    (m1_perr),
        .s_paddr    (s_paddr),
        .s_pdata    (s_pdata),
        .s_pstb     (s_pstb),
        .s_psel     (s_psel),
        .s_penable  (s_penable),
        .s_pwrite   (s_pwrite),
        .s_prdata   (s_prdata),
        .s_pready   (s_pready),
        .s_perr     (s_perr),
        .grant      (grant),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // reference-model state: index of the master that owned the last transfer
    int last_m = 1;

    // slave behaviour: answer after slv_wait extra ACCESS cycles, or never
    int          slv_wait = 0;
    bit          slv_hang = 1'b0;
    logic [31:0] slv_data = '0;
    bit          slv_err  = 1'b0;
    int          acc_n    = 0;

    initial begin
        s_pready = 1'b0;
        s_prdata = '0;
        s_perr   = 1'b0;
        forever begin
            @(negedge clk);
            if (s_psel && s_penable) begin
                s_pready = !slv_hang && (acc_n == slv_wait);
                s_prdata = slv_data;
                s_perr   = slv_err;
                acc_n    = acc_n + 1;
            end else begin
                s_pready = 1'b0;
                s_prdata = '0;
                s_perr   = 1'b0;
                acc_n    = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // round-robin rule: a lone requester wins, a tie goes to the master that
    // was not granted last
    function automatic int pick(input bit r0, input bit r1);
        if (r0 && r1) return (last_m == 0) ? 1 : 0;
        return r0 ? 0 : 1;
    endfunction

    task automatic set_m(input int idx, input bit sel, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] stb, input bit wr);
        if (idx == 0) begin
            m0_psel = sel; m0_paddr = a; m0_pdata = d; m0_pstb = stb; m0_pwrite = wr;
        end else begin
            m1_psel = sel; m1_paddr = a; m1_pdata = d; m1_pstb = stb; m1_pwrite = wr;
        end
    endtask

    // Called at a sample point with the DUT idle and requests already driven.
    // Runs the transfer owned by 'own' to completion and checks every cycle,
    // then checks the idle cycle that follows the response.
    task automatic serve(input int own, input int w, input bit hang,
                         input logic [31:0] rdata, input bit err, input bit scramble);
        logic [31:0] ea, ed;
        logic [3:0]  es;
        bit          ewr, tmo;
        int          lat;
        logic [31:0] exp_data;
        bit          exp_err;
        logic        own_rdy, oth_rdy, oth_err;
        logic [31:0] own_dat;
        logic        own_err;

        ea  = own ? m1_paddr  : m0_paddr;
        ed  = own ? m1_pdata  : m0_pdata;
        es  = own ? m1_pstb   : m0_pstb;
        ewr = own ? m1_pwrite : m0_pwrite;
        slv_wait = w; slv_hang = hang; slv_data = rdata; slv_err = err;

        tmo      = hang || (w >= TO);
        lat      = tmo ? (2 + TO) : (3 + w);
        exp_data = (tmo || ewr) ? 32'h0 : rdata;
        exp_err  = tmo ? 1'b1 : err;

        for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            own_rdy = own ? m1_pready : m0_pready;
            own_dat = own ? m1_prdata : m0_prdata;
            own_err = own ? m1_perr   : m0_perr;
            oth_rdy = own ? m0_pready : m1_pready;
            oth_err = own ? m0_perr   : m1_perr;
            chk("grant", grant, own ? 2'b10 : 2'b01);
            chk("busy", busy, 1'b1);
            chk("s_psel", s_psel, k < lat);
            chk("s_penable", s_penable, (k >= 2) && (k < lat));
            if (k < lat) begin
                chk("s_paddr", s_paddr, ea);
                chk("s_pdata", s_pdata, ed);
                chk("s_pstb", s_pstb, es);
                chk("s_pwrite", s_pwrite, ewr);
            end
            chk("owner_pready", own_rdy, k == lat);
            chk("other_pready", oth_rdy, 1'b0);
            chk("other_perr", oth_err, 1'b0);
            if (k == lat) begin
                chk("owner_prdata", own_dat, exp_data);
                chk("owner_perr", own_err, exp_err);
            end
            if (k == 1 && scramble) begin
                // the captured copy must be immune to later master activity
                if (own == 0) begin
                    m0_paddr = $urandom; m0_pdata = $urandom; m0_psel = 1'($urandom_range(0, 1));
                end else begin
                    m1_paddr = $urandom; m1_pdata = $urandom; m1_psel = 1'($urandom_range(0, 1));
                end
            end
        end
        @(posedge clk); #1;
        chk("idle_grant", grant, 2'b00);
        chk("idle_busy", busy, 1'b0);
        chk("idle_pready", {m1_pready, m0_pready}, 2'b00);
        last_m = own;
    endtask

    task automatic do_reset();
        m0_psel = 1'b0; m1_psel = 1'b0;
        @(negedge clk); rts_n = 1'b0;
        @(negedge clk); rts_n = 1'b1;
        last_m = 1;
        @(posedge clk); #1;
    endtask

    initial begin
        rts_n = 1'b0;
        m0_penable = 1'b0; m1_penable = 1'b0;
        set_m(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        set_m(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_slave", {s_psel, s_penable, s_pwrite}, 3'b000);
        chk("rst_paddr", s_paddr, 32'h0);
        chk("rst_ready", {m0_pready, m1_pready, m0_perr, m1_perr}, 4'h0);
        chk("rst_prdata", m0_prdata | m1_prdata, 32'h0);
        @(negedge clk); rts_n = 1'b1;
        @(posedge clk); #1;

        // master 0 zero-wait read
        set_m(0, 1'b1, 32'h1000, 32'h0, 4'hF, 1'b0);
        serve(pick(1'b1, 1'b0), 0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);

        // both masters request continuously from reset: 01,10,01,10
        do_reset();
        set_m(0, 1'b1, 32'h0000_0100, 32'h0, 4'hF, 1'b0);
        set_m(1, 1'b1, 32'h0000_0200, 32'h0, 4'hF, 1'b0);
        for (int i = 0; i < 4; i++)
            serve(pick(1'b1, 1'b1), i, 1'b0, 32'hA000_0000 + i, 1'b0, 1'b0);

        // master 1 write with four wait states
        set_m(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        set_m(1, 1'b1, 32'h20, 32'h55AA00FF, 4'b0011, 1'b1);
        serve(pick(1'b0, 1'b1), 4, 1'b0, 32'h1234_5678, 1'b0, 1'b0);

        // hung slave on a master 0 read
        set_m(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        set_m(0, 1'b1, 32'h3000, 32'h0, 4'hF, 1'b0);
        serve(pick(1'b1, 1'b0), 0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // slave needs exactly TO ACCESS cycles: real response, no timeout
        serve(pick(1'b1, 1'b0), TO - 1, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0);

        // slave error on a master 0 write
        set_m(0, 1'b1, 32'h4000, 32'h0BAD_0BAD, 4'hF, 1'b1);
        serve(pick(1'b1, 1'b0), 1, 1'b0, 32'h7777_7777, 1'b1, 1'b0);

        // reset pulse during ACCESS abandons the transfer
        set_m(0, 1'b1, 32'h5000, 32'h1111_2222, 4'hC, 1'b1);
        slv_wait = 5; slv_hang = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_access", {s_psel, s_penable}, 2'b11);
        #2 rts_n = 1'b0;
        #1;
        chk("arst_grant", grant, 2'b00);
        chk("arst_busy", busy, 1'b0);
        chk("arst_slave", {s_psel, s_penable, s_pwrite, s_pstb}, 7'h0);
        chk("arst_saddr", s_paddr | s_pdata, 32'h0);
        chk("arst_ready", {m0_pready, m1_pready, m0_perr, m1_perr}, 4'h0);
        set_m(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        @(posedge clk); #1;
        chk("arst_hold", {busy, m0_pready, m1_pready}, 3'b000);
        @(negedge clk); rts_n = 1'b1;
        last_m = 1;
        @(posedge clk); #1;
        chk("arst_no_resp", {busy, m0_pready, m1_pready}, 3'b000);
        set_m(0, 1'b1, 32'h6000, 32'h0, 4'hF, 1'b0);
        set_m(1, 1'b1, 32'h7000, 32'h0, 4'hF, 1'b0);
        serve(pick(1'b1, 1'b1), 0, 1'b0, 32'h0600_0006, 1'b0, 1'b0);

        // randomized transfers
        for (int i = 0; i < 30; i++) begin
            int  r;
            bit  r0, r1;
            r  = $urandom_range(1, 3);
            r0 = r[0];
            r1 = r[1];
            set_m(0, r0, $urandom, $urandom, 4'($urandom), 1'($urandom));
            set_m(1, r1, $urandom, $urandom, 4'($urandom), 1'($urandom));
            serve(pick(r0, r1), $urandom_range(0, 9), ($urandom_range(0, 7) == 0),
                  $urandom, 1'($urandom), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
